// File: rtl/hplvds_rx_ctrl.sv
// Power-up sequencer and link-state controller for one HPLVDS differential RX pad.
// Times the termination/bias/enable steps, holds the analog trims and qualifies RX data.
module hplvds_rx_ctrl #(
    parameter int unsigned T_TERM = 16,
    parameter int unsigned T_VCM  = 64,
    parameter int unsigned T_RX   = 32,
    parameter int unsigned EI_DEB = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             ac_coupled,
    input  logic             cfg_pol,
    input  logic [3:0]       cfg_trim,
    input  logic [2:0]       cfg_gain,
    input  logic [6:0]       cfg_ctle_res,
    input  logic [2:0]       cfg_ctle_cap,
    input  logic             pad_di,
    input  logic             pad_ei,
    output logic             rterm_en,
    output logic [3:0]       rterm_trim,
    output logic             rx_vcm_en,
    output logic             rx_en,
    output logic             rx_pol,
    output logic [2:0]       rx_gain,
    output logic [6:0]       rx_ctle_res,
    output logic [2:0]       rx_ctle_cap,
    output logic             ei_detect_en,
    output logic             rx_data,
    output logic             rx_valid,
    output logic             elec_idle,
    output logic             ready
);

    localparam logic [2:0] S_OFF    = 3'd0;
    localparam logic [2:0] S_TERM   = 3'd1;
    localparam logic [2:0] S_VCM    = 3'd2;
    localparam logic [2:0] S_RXON   = 3'd3;
    localparam logic [2:0] S_ACTIVE = 3'd4;
    localparam logic [2:0] S_EIDLE  = 3'd5;

    localparam logic [CNT_W-1:0] T_TERM_C = CNT_W'(T_TERM);
    localparam logic [CNT_W-1:0] T_VCM_C  = CNT_W'(T_VCM);
    localparam logic [CNT_W-1:0] T_RX_C   = CNT_W'(T_RX);
    localparam logic [CNT_W-1:0] EI_DEB_C = CNT_W'(EI_DEB);

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt, timer_inc;
    logic [CNT_W-1:0] ei_cnt, ei_nxt, ei_inc;
    logic             latch_cfg;

    logic             di_s1, sdi, ei_s1, sei;

    logic             ac_q, pol_q;
    logic [3:0]       trim_q;
    logic [2:0]       gain_q, cap_q;
    logic [6:0]       res_q;

    logic             on, powered, vcm_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            di_s1 <= 1'b0;
            sdi   <= 1'b0;
            ei_s1 <= 1'b0;
            sei   <= 1'b0;
        end else begin
            di_s1 <= pad_di;
            sdi   <= di_s1;
            ei_s1 <= pad_ei;
            sei   <= ei_s1;
        end
    end

    // Counters saturate at all-ones; the value compared is the count including this cycle.
    always_comb begin
        timer_inc = (timer == '1) ? timer : timer + 1'b1;
        ei_inc    = (ei_cnt == '1) ? ei_cnt : ei_cnt + 1'b1;
        state_nxt = state;
        timer_nxt = timer;
        ei_nxt    = ei_cnt;
        latch_cfg = 1'b0;
        case (state)
            S_OFF: begin
                timer_nxt = '0;
                ei_nxt    = '0;
                if (enable) begin
                    state_nxt = S_TERM;
                    latch_cfg = 1'b1;
                end
            end
            S_TERM: begin
                if (timer_inc == T_TERM_C) begin
                    state_nxt = ac_q ? S_VCM : S_RXON;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            S_VCM: begin
                if (timer_inc == T_VCM_C) begin
                    state_nxt = S_RXON;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            S_RXON: begin
                if (timer_inc == T_RX_C) begin
                    state_nxt = S_ACTIVE;
                    timer_nxt = '0;
                    ei_nxt    = '0;
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            S_ACTIVE: begin
                if (!sei) begin
                    ei_nxt = '0;
                end else if (ei_inc == EI_DEB_C) begin
                    state_nxt = S_EIDLE;
                    ei_nxt    = '0;
                end else begin
                    ei_nxt = ei_inc;
                end
            end
            S_EIDLE: begin
                if (sei) begin
                    ei_nxt = '0;
                end else if (ei_inc == EI_DEB_C) begin
                    state_nxt = S_ACTIVE;
                    ei_nxt    = '0;
                end else begin
                    ei_nxt = ei_inc;
                end
            end
            default: begin
                state_nxt = S_OFF;
                timer_nxt = '0;
                ei_nxt    = '0;
            end
        endcase
        // Shutdown wins over any timer or idle-detect transition.
        if (!enable && state != S_OFF) begin
            state_nxt = S_OFF;
            timer_nxt = '0;
            ei_nxt    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_OFF;
            timer  <= '0;
            ei_cnt <= '0;
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            ei_cnt <= ei_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac_q   <= 1'b0;
            pol_q  <= 1'b0;
            trim_q <= '0;
            gain_q <= '0;
            res_q  <= '0;
            cap_q  <= '0;
        end else if (latch_cfg) begin
            ac_q   <= ac_coupled;
            pol_q  <= cfg_pol;
            trim_q <= cfg_trim;
            gain_q <= cfg_gain;
            res_q  <= cfg_ctle_res;
            cap_q  <= cfg_ctle_cap;
        end
    end

    assign on      = (state != S_OFF);
    assign powered = (state == S_RXON) || (state == S_ACTIVE) || (state == S_EIDLE);
    assign vcm_on  = ac_q && (powered || (state == S_VCM));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rterm_en     <= 1'b0;
            rterm_trim   <= '0;
            rx_vcm_en    <= 1'b0;
            rx_en        <= 1'b0;
            rx_pol       <= 1'b0;
            rx_gain      <= '0;
            rx_ctle_res  <= '0;
            rx_ctle_cap  <= '0;
            ei_detect_en <= 1'b0;
            rx_data      <= 1'b0;
            rx_valid     <= 1'b0;
            elec_idle    <= 1'b0;
            ready        <= 1'b0;
        end else begin
            rterm_en     <= on;
            rterm_trim   <= on ? trim_q : '0;
            rx_vcm_en    <= vcm_on;
            rx_en        <= powered;
            rx_pol       <= on & pol_q;
            rx_gain      <= on ? gain_q : '0;
            rx_ctle_res  <= on ? res_q : '0;
            rx_ctle_cap  <= on ? cap_q : '0;
            ei_detect_en <= powered;
            rx_data      <= (state == S_ACTIVE) & sdi;
            rx_valid     <= (state == S_ACTIVE);
            elec_idle    <= (state == S_EIDLE);
            ready        <= (state == S_ACTIVE) || (state == S_EIDLE);
        end
    end

endmodule

// File: tb/tb_hplvds_rx_ctrl.sv
// Scoreboard bench for hplvds_rx_ctrl: stimulus queues timed output events,
// a negedge monitor matches every output change (and snapshots) against them.
module tb_hplvds_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, ac_coupled, cfg_pol;
    logic [3:0] cfg_trim;
    logic [2:0] cfg_gain, cfg_ctle_cap;
    logic [6:0] cfg_ctle_res;
    logic       pad_di, pad_ei;
    logic       rterm_en, rx_vcm_en, rx_en, rx_pol, ei_detect_en;
    logic       rx_data, rx_valid, elec_idle, ready;
    logic [3:0] rterm_trim;
    logic [2:0] rx_gain, rx_ctle_cap;
    logic [6:0] rx_ctle_res;

    hplvds_rx_ctrl #(.T_TERM(16), .T_VCM(64), .T_RX(32), .EI_DEB(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ac_coupled(ac_coupled),
        .cfg_pol(cfg_pol), .cfg_trim(cfg_trim), .cfg_gain(cfg_gain),
        .cfg_ctle_res(cfg_ctle_res), .cfg_ctle_cap(cfg_ctle_cap),
        .pad_di(pad_di), .pad_ei(pad_ei),
        .rterm_en(rterm_en), .rterm_trim(rterm_trim), .rx_vcm_en(rx_vcm_en),
        .rx_en(rx_en), .rx_pol(rx_pol), .rx_gain(rx_gain),
        .rx_ctle_res(rx_ctle_res), .rx_ctle_cap(rx_ctle_cap),
        .ei_detect_en(ei_detect_en), .rx_data(rx_data), .rx_valid(rx_valid),
        .elec_idle(elec_idle), .ready(ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       pol;
        logic [3:0] trim;
        logic [2:0] gain;
        logic [6:0] res;
        logic [2:0] cap;
    } cfg_t;

    typedef struct {
        string       name;
        int          cyc;
        bit          snap;
        logic [25:0] v;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;
    logic [25:0] prev = '0;
    logic [25:0] obs;

    localparam int ST_OFF = 0, ST_TERM = 1, ST_VCM = 2, ST_RXON = 3, ST_ACT = 4, ST_IDLE = 5;

    // Expected pad/core outputs for a given sequencer phase.
    function automatic logic [25:0] ev(int st, bit ac, cfg_t c, bit d);
        logic on, vcm, rx, act, idl;
        on  = (st != ST_OFF);
        vcm = ac && (st >= ST_VCM);
        rx  = (st >= ST_RXON);
        act = (st == ST_ACT);
        idl = (st == ST_IDLE);
        return {on, vcm, rx, rx, act, idl, act | idl, act & d,
                on ? {c.gain, c.trim, c.pol, c.res, c.cap} : 18'b0};
    endfunction

    task automatic push_ev(string name, int at, logic [25:0] v);
        exp_t e;
        e.name = name; e.cyc = at; e.snap = 1'b0; e.v = v;
        sb.push_back(e);
    endtask

    task automatic push_snap(string name, int at, logic [25:0] v);
        exp_t e;
        e.name = name; e.cyc = at; e.snap = 1'b1; e.v = v;
        sb.push_back(e);
    endtask

    task automatic tick_to(int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_cfg(cfg_t c);
        cfg_pol = c.pol; cfg_trim = c.trim; cfg_gain = c.gain;
        cfg_ctle_res = c.res; cfg_ctle_cap = c.cap;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            obs = {rterm_en, rx_vcm_en, rx_en, ei_detect_en, rx_valid, elec_idle, ready,
                   rx_data, rx_gain, rterm_trim, rx_pol, rx_ctle_res, rx_ctle_cap};
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s missing at cyc=%0d exp=%h (now cyc=%0d got=%h)",
                         sb[0].name, sb[0].cyc, sb[0].v, cyc, obs);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].snap && sb[0].cyc == cyc) begin
                checks++;
                if (obs !== sb[0].v) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", sb[0].name, cyc, obs, sb[0].v);
                end
                void'(sb.pop_front());
            end
            if (obs !== prev) begin
                checks++;
                if (sb.size() > 0 && !sb[0].snap) begin
                    if (sb[0].cyc != cyc || obs !== sb[0].v) begin
                        failures++;
                        $display("FAIL %s got cyc=%0d val=%h exp cyc=%0d val=%h",
                                 sb[0].name, cyc, obs, sb[0].cyc, sb[0].v);
                    end
                    void'(sb.pop_front());
                end else begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d got=%h prev=%h", cyc, obs, prev);
                end
            end
            prev = obs;
        end
    end

    initial begin
        cfg_t a, b;
        int c, c1, c2, d0, p, q, r, s, t, u, v;
        a = '{pol: 1'b1, trim: 4'hA, gain: 3'b101, res: 7'h55, cap: 3'b011};
        b = '{pol: 1'b0, trim: 4'h5, gain: 3'b010, res: 7'h2A, cap: 3'b100};

        rst_n = 1'b1; enable = 1'b0; ac_coupled = 1'b0;
        apply_cfg('0);
        pad_di = 1'b1; pad_ei = 1'b0;
        #2 rst_n = 1'b0;
        #1 mon_en = 1'b1;
        push_snap("reset_state", 2, '0);
        tick_to(3);
        rst_n = 1'b1;

        // AC-coupled bring-up with config A
        tick_to(5);
        c = cyc;
        apply_cfg(a); ac_coupled = 1'b1; enable = 1'b1;
        push_ev("ac1_term",   c + 2,   ev(ST_TERM, 1, a, 1));
        push_ev("ac1_vcm",    c + 18,  ev(ST_VCM,  1, a, 1));
        push_ev("ac1_rxon",   c + 82,  ev(ST_RXON, 1, a, 1));
        push_ev("ac1_active", c + 114, ev(ST_ACT,  1, a, 1));
        tick_to(c + 120);
        cfg_gain = 3'b010;
        push_snap("gain_held", c + 125, ev(ST_ACT, 1, a, 1));

        // 7 idle cycles must not trip the debounce
        tick_to(c + 130);
        c1 = cyc;
        pad_ei = 1'b1;
        push_snap("ei7_no_idle", c1 + 15, ev(ST_ACT, 1, a, 1));
        tick_to(c1 + 7);
        pad_ei = 1'b0;
        tick_to(c1 + 20);

        c2 = cyc;
        pad_ei = 1'b1;
        push_ev("eidle_enter", c2 + 11, ev(ST_IDLE, 1, a, 1));
        tick_to(c2 + 14);
        d0 = cyc;
        pad_ei = 1'b0;
        push_ev("eidle_exit", d0 + 11, ev(ST_ACT, 1, a, 1));
        tick_to(d0 + 15);

        p = cyc;
        pad_di = 1'b0;
        push_ev("data_low", p + 3, ev(ST_ACT, 1, a, 0));
        tick_to(p + 6);
        pad_di = 1'b1;
        push_ev("data_high", p + 9, ev(ST_ACT, 1, a, 1));
        tick_to(p + 12);

        // Disable, then DC-coupled re-enable picks up the new config
        q = cyc;
        enable = 1'b0;
        push_ev("disable_active", q + 2, '0);
        tick_to(q + 5);
        r = cyc;
        apply_cfg(b); ac_coupled = 1'b0; enable = 1'b1;
        push_ev("ac0_term",   r + 2,  ev(ST_TERM, 0, b, 1));
        push_ev("ac0_rxon",   r + 18, ev(ST_RXON, 0, b, 1));
        push_ev("ac0_active", r + 50, ev(ST_ACT,  0, b, 1));
        tick_to(r + 55);

        // Abort during VCM and restart from TERM
        s = cyc;
        enable = 1'b0;
        push_ev("disable_ac0", s + 2, '0);
        tick_to(s + 5);
        t = cyc;
        apply_cfg(a); ac_coupled = 1'b1; enable = 1'b1;
        push_ev("abort_term", t + 2,  ev(ST_TERM, 1, a, 1));
        push_ev("abort_vcm",  t + 18, ev(ST_VCM,  1, a, 1));
        tick_to(t + 30);
        enable = 1'b0;
        push_ev("abort_off", t + 32, '0);
        tick_to(t + 35);
        u = cyc;
        enable = 1'b1;
        push_ev("restart_term",   u + 2,   ev(ST_TERM, 1, a, 1));
        push_ev("restart_vcm",    u + 18,  ev(ST_VCM,  1, a, 1));
        push_ev("restart_rxon",   u + 82,  ev(ST_RXON, 1, a, 1));
        push_ev("restart_active", u + 114, ev(ST_ACT,  1, a, 1));
        tick_to(u + 120);

        // Async reset while active, enable held high throughout
        v = cyc;
        rst_n = 1'b0;
        push_ev("async_reset", v, '0);
        tick_to(v + 2);
        rst_n = 1'b1;
        push_ev("post_rst_term",   v + 4,   ev(ST_TERM, 1, a, 1));
        push_ev("post_rst_vcm",    v + 20,  ev(ST_VCM,  1, a, 1));
        push_ev("post_rst_rxon",   v + 84,  ev(ST_RXON, 1, a, 1));
        push_ev("post_rst_active", v + 116, ev(ST_ACT,  1, a, 1));
        tick_to(v + 125);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
